uart_rx: RTL and testbench

//   Serial receive front end for the UART path: samples the asynchronous rx pin, recovers 8N1 frames
//   (1 start, 8 data LSB-first, 1 stop) and emits each byte as a one-cycle rx_data/rx_data_valid pulse.

---
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Synchronises the asynchronous rx line, finds the
// start bit, samples every bit in the middle of its period and emits each good
// byte as a one-cycle rx_data_valid pulse. A low stop bit gives a one-cycle
// frame_error pulse, and the line must return high before the next frame is accepted.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    data_next;
    logic          valid_next;
    logic          ferr_next;
    logic          rx_meta;
    logic          rx_s;

    // Two-flop synchroniser; both flops reset to the idle-high line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counter, shifter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            shift_reg     <= 8'h00;
            bit_idx       <= 3'd0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            shift_reg     <= shift_next;
            bit_idx       <= bit_idx_next;
            rx_data       <= data_next;
            rx_data_valid <= valid_next;
            frame_error   <= ferr_next;
        end
    end

    // Next-state logic: the counter restarts on every state change and after each sample,
    // and both pulses fall back to zero unless the stop sample raises one of them
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        data_next    = rx_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks every cycle against a
// reference model that derives the sample instants from the start-edge time.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_error;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    logic       m1 = 1'b1;
    logic       m2 = 1'b1;
    logic       rs;
    logic       m_active = 1'b0;
    logic       m_break = 1'b0;
    int         m_edge = 0;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;

    // observed DUT activity
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] byte_q[$];
    int         time_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .frame_error  (frame_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is timed entirely from the edge where the synchronised line
    // was first seen low; start, data and stop samples fall at fixed offsets from that edge
    always @(posedge clk) begin
        int rel;
        cyc++;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (reset) begin
            m1       = 1'b1;
            m2       = 1'b1;
            m_active = 1'b0;
            m_break  = 1'b0;
            m_data   = 8'h00;
        end else begin
            rs = m2;
            m2 = m1;
            m1 = rx;
            if (m_break) begin
                if (rs) m_break = 1'b0;
            end else if (!m_active) begin
                if (!rs) begin
                    m_active = 1'b1;
                    m_edge   = cyc;
                end
            end else begin
                rel = cyc - m_edge;
                if (rel == HALF && rs) m_active = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (rel == HALF + (k + 1) * CPB) m_bits[k] = rs;
                end
                if (rel == HALF + 9 * CPB) begin
                    m_active = 1'b0;
                    if (rs) begin
                        m_valid = 1'b1;
                        m_data  = m_bits;
                    end else begin
                        m_ferr  = 1'b1;
                        m_break = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare between the DUT and the model, plus pulse-shape rules and activity log
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            checkOutput("rx_data_valid", rx_data_valid, m_valid);
            checkOutput("frame_error", frame_error, m_ferr);
            checkOutput("rx_data", rx_data, m_data);
            checkOutput("rx_busy", rx_busy, m_active || m_break);
            checkOutput("pulse_exclusive", rx_data_valid & frame_error, 1'b0);
            checkOutput("pulse_single_cycle", (rx_data_valid & prev_valid) | (frame_error & prev_ferr), 1'b0);
            if (rx_data_valid === 1'b1) begin
                valid_cnt++;
                byte_q.push_back(rx_data);
                time_q.push_back(cyc);
            end
            if (frame_error === 1'b1) ferr_cnt++;
            prev_valid = rx_data_valid;
            prev_ferr  = frame_error;
        end else begin
            prev_valid = 1'b0;
            prev_ferr  = 1'b0;
        end
    end

    // Sends one frame starting at a falling clock edge; abort_pos >= 0 resets the DUT
    // halfway through that bit position (0 = start bit, 1..8 = data bits) and abandons the frame
    task automatic applyStimulus(input logic [7:0] data, input int period, input logic stop_val,
                                 input int abort_pos);
        logic val;
        for (int pos = 0; pos < 10; pos++) begin
            if (pos == 0) val = 1'b0;
            else if (pos == 9) val = stop_val;
            else val = data[pos-1];
            rx = val;
            if (pos == abort_pos) begin
                repeat (period / 2) @(negedge clk);
                reset = 1'b1;
                #1;
                checkOutput("abort_rx_data", rx_data, 8'h00);
                checkOutput("abort_valid", rx_data_valid, 1'b0);
                checkOutput("abort_ferr", frame_error, 1'b0);
                checkOutput("abort_busy", rx_busy, 1'b0);
                rx = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic idleLine(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic holdLow(input int n);
        rx = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Directed scenarios followed by randomised frames
    initial begin
        int v0;
        int f0;
        logic [7:0] b;
        int p;
        logic bad;

        reset = 1'b0;
        rx    = 1'b1;
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_valid", rx_data_valid, 1'b0);
        checkOutput("reset_ferr", frame_error, 1'b0);
        checkOutput("reset_busy", rx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idleLine(20);

        $display("[TB] single frame 0x55");
        v0 = valid_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'h55, CPB, 1'b1, -1);
        idleLine(30);
        checkOutput("t1_valid_count", valid_cnt - v0, 1);
        checkOutput("t1_byte", rx_data, 8'h55);
        checkOutput("t1_model_byte", m_data, 8'h55);
        checkOutput("t1_ferr_count", ferr_cnt - f0, 0);
        checkOutput("t1_busy_after", rx_busy, 1'b0);

        $display("[TB] back-to-back 0xA3 0x0F");
        v0 = valid_cnt;
        applyStimulus(8'hA3, CPB, 1'b1, -1);
        applyStimulus(8'h0F, CPB, 1'b1, -1);
        idleLine(30);
        checkOutput("t2_valid_count", valid_cnt - v0, 2);
        if (byte_q.size() >= 2) begin
            checkOutput("t2_first_byte", byte_q[byte_q.size()-2], 8'hA3);
            checkOutput("t2_second_byte", byte_q[byte_q.size()-1], 8'h0F);
            checkOutput("t2_spacing", time_q[time_q.size()-1] - time_q[time_q.size()-2], 10 * CPB);
        end

        $display("[TB] short low glitch");
        v0 = valid_cnt;
        f0 = ferr_cnt;
        holdLow(4);
        idleLine(30);
        checkOutput("t3_valid_count", valid_cnt - v0, 0);
        checkOutput("t3_ferr_count", ferr_cnt - f0, 0);
        checkOutput("t3_busy_after", rx_busy, 1'b0);
        checkOutput("t3_byte_kept", rx_data, 8'h0F);

        $display("[TB] bad stop bit then held-low line");
        v0 = valid_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'hFF, CPB, 1'b0, -1);
        holdLow(80);
        idleLine(32);
        checkOutput("t4_ferr_count", ferr_cnt - f0, 1);
        checkOutput("t4_valid_count", valid_cnt - v0, 0);
        checkOutput("t4_byte_kept", rx_data, 8'h0F);
        applyStimulus(8'h3C, CPB, 1'b1, -1);
        idleLine(30);
        checkOutput("t4_recover_count", valid_cnt - v0, 1);
        checkOutput("t4_recover_byte", rx_data, 8'h3C);

        $display("[TB] reset during data bit 4");
        v0 = valid_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'h81, CPB, 1'b1, 5);
        idleLine(40);
        checkOutput("t5_no_valid", valid_cnt - v0, 0);
        checkOutput("t5_no_ferr", ferr_cnt - f0, 0);
        checkOutput("t5_byte_cleared", rx_data, 8'h00);
        applyStimulus(8'h81, CPB, 1'b1, -1);
        idleLine(30);
        checkOutput("t5_fresh_count", valid_cnt - v0, 1);
        checkOutput("t5_fresh_byte", rx_data, 8'h81);

        $display("[TB] sender bit periods 15 and 17");
        v0 = valid_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'hC6, 15, 1'b1, -1);
        idleLine(30);
        checkOutput("t6_fast_byte", rx_data, 8'hC6);
        applyStimulus(8'hC6, 17, 1'b1, -1);
        idleLine(30);
        checkOutput("t6_slow_byte", rx_data, 8'hC6);
        checkOutput("t6_count", valid_cnt - v0, 2);
        checkOutput("t6_no_ferr", ferr_cnt - f0, 0);
        // A 1/16 period error drifts past mid-bit by the last bits of 0x39, so only the model judges these
        applyStimulus(8'h39, 15, 1'b1, -1);
        idleLine(30);
        applyStimulus(8'h39, 17, 1'b1, -1);
        idleLine(40);

        $display("[TB] randomised frames");
        for (int i = 0; i < 24; i++) begin
            b   = 8'($urandom);
            p   = 15 + $urandom_range(0, 2);
            bad = ($urandom_range(0, 7) == 0);
            applyStimulus(b, p, !bad, -1);
            if (bad) idleLine(3 * p);
            else idleLine($urandom_range(0, 20));
        end
        idleLine(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario never returns
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion before time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
